csr_regfile: RTL and testbench

CSR_REGFILE -- requirements
Module: csr_regfile

---
 rtl/csr_regfile.sv | 166 ++++++++++++++++
 tb/tb_csr_regfile.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
//==============================================================================
// Module      : csr_regfile
// Description : Machine-mode CSR file holding mtvec, mepc and mstatus.
//               Executes CSRRW/RS/RC and their immediate forms, and runs the
//               ECALL trap-entry / MRET trap-return sequences that end in a
//               one-cycle PC redirect strobe.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module csr_regfile #(
    parameter logic [31:0] RESET_MTVEC  = 32'h0000_0000,
    parameter logic [31:0] MSTATUS_MASK = 32'h0000_1888
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] csrregin_inst,
    input  logic        csrregin_csr_write,
    input  logic        csrregin_valid,
    input  logic [31:0] csrregin_rs1_data,
    input  logic [31:0] csrregin_pc,
    output logic [31:0] csrregout_rdata,
    output logic        csrregout_busy,
    output logic        csrregout_redirect,
    output logic [31:0] csrregout_redirect_pc,
    output logic [31:0] csrregout_mtvec,
    output logic [31:0] csrregout_mepc,
    output logic [31:0] csrregout_mstatus
);

    localparam logic [11:0] c_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] c_ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] c_ADDR_MEPC    = 12'h341;
    localparam logic [6:0]  c_OP_SYSTEM    = 7'h73;
    localparam logic [31:0] c_INST_ECALL   = 32'h0000_0073;
    localparam logic [31:0] c_INST_MRET    = 32'h3020_0073;
    localparam logic [31:0] c_MSTATUS_RST  = 32'h0000_1800;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        TRAP_SAVE   = 2'd1,
        RET_RESTORE = 2'd2,
        REDIRECT    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mstatus;
    logic [31:0] r_target;
    logic [31:0] r_pc_cap;

    logic [11:0] w_addr;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1_field;
    logic        w_is_csr_op;
    logic        w_hit_mtvec;
    logic        w_hit_mepc;
    logic        w_hit_mstatus;
    logic [31:0] w_src;
    logic [31:0] w_old;
    logic [31:0] w_new;
    logic        w_write_en;
    logic        w_accept_ecall;
    logic        w_accept_mret;

    assign w_addr      = csrregin_inst[31:20];
    assign w_funct3    = csrregin_inst[14:12];
    assign w_rs1_field = csrregin_inst[19:15];

    // funct3[1:0]==00 covers ECALL/MRET (000) and the reserved 100 encoding
    assign w_is_csr_op   = (csrregin_inst[6:0] == c_OP_SYSTEM) && (w_funct3[1:0] != 2'b00);
    assign w_hit_mtvec   = w_is_csr_op && (w_addr == c_ADDR_MTVEC);
    assign w_hit_mepc    = w_is_csr_op && (w_addr == c_ADDR_MEPC);
    assign w_hit_mstatus = w_is_csr_op && (w_addr == c_ADDR_MSTATUS);

    // funct3[2] selects the zero-extended 5-bit immediate as the source
    assign w_src = w_funct3[2] ? {27'd0, w_rs1_field} : csrregin_rs1_data;

    // Old value of the addressed CSR and the value the op would produce
    always_comb begin
        w_old = 32'd0;
        if (w_hit_mtvec)   w_old = r_mtvec;
        if (w_hit_mepc)    w_old = r_mepc;
        if (w_hit_mstatus) w_old = r_mstatus;
        case (w_funct3[1:0])
            2'b01:   w_new = w_src;
            2'b10:   w_new = w_old | w_src;
            2'b11:   w_new = w_old & ~w_src;
            default: w_new = w_old;
        endcase
    end

    // Set/clear forms with a zero rs1/uimm field are pure reads
    assign w_write_en = csrregin_valid && csrregin_csr_write && (r_state == IDLE) &&
                        w_is_csr_op && !(w_funct3[1] && (w_rs1_field == 5'd0));

    assign w_accept_ecall = csrregin_valid && (r_state == IDLE) && (csrregin_inst == c_INST_ECALL);
    assign w_accept_mret  = csrregin_valid && (r_state == IDLE) && (csrregin_inst == c_INST_MRET);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic for the trap-entry / trap-return sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept_ecall)     w_state_nxt = TRAP_SAVE;
                else if (w_accept_mret) w_state_nxt = RET_RESTORE;
            end
            TRAP_SAVE:   w_state_nxt = REDIRECT;
            RET_RESTORE: w_state_nxt = REDIRECT;
            default:     w_state_nxt = IDLE;
        endcase
    end

    // CSR storage: software writes in IDLE, hardware updates in save/restore
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mtvec   <= RESET_MTVEC;
            r_mepc    <= 32'd0;
            r_mstatus <= c_MSTATUS_RST;
            r_target  <= 32'd0;
            r_pc_cap  <= 32'd0;
        end else begin
            if (w_accept_ecall) r_pc_cap <= csrregin_pc;
            case (r_state)
                TRAP_SAVE: begin
                    r_mepc         <= {r_pc_cap[31:2], 2'b00};
                    r_mstatus[7]   <= r_mstatus[3];
                    r_mstatus[3]   <= 1'b0;
                    r_mstatus[12:11] <= 2'b11;
                    r_target       <= r_mtvec;
                end
                RET_RESTORE: begin
                    r_mstatus[3]   <= r_mstatus[7];
                    r_mstatus[7]   <= 1'b1;
                    r_mstatus[12:11] <= 2'b11;
                    r_target       <= r_mepc;
                end
                default: begin
                    if (w_write_en && w_hit_mtvec)   r_mtvec <= {w_new[31:2], 2'b00};
                    if (w_write_en && w_hit_mepc)    r_mepc  <= {w_new[31:2], 2'b00};
                    if (w_write_en && w_hit_mstatus)
                        r_mstatus <= (r_mstatus & ~MSTATUS_MASK) | (w_new & MSTATUS_MASK);
                end
            endcase
        end
    end

    assign csrregout_rdata       = w_old;
    assign csrregout_busy        = (r_state != IDLE);
    assign csrregout_redirect    = (r_state == REDIRECT);
    assign csrregout_redirect_pc = (r_state == REDIRECT) ? r_target : 32'd0;
    assign csrregout_mtvec       = r_mtvec;
    assign csrregout_mepc        = r_mepc;
    assign csrregout_mstatus     = r_mstatus;

endmodule

`default_nettype wire

// File: tb/tb_csr_regfile.sv
//==============================================================================
// Module      : tb_csr_regfile
// Description : Self-checking bench for csr_regfile: directed vectors, a
//               behavioural CSR/trap model, and a per-cycle compare process.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_csr_regfile;

    localparam logic [31:0] c_RESET_MTVEC = 32'h0000_0000;
    localparam logic [31:0] c_MASK        = 32'h0000_1888;
    localparam logic [31:0] c_ECALL       = 32'h0000_0073;
    localparam logic [31:0] c_MRET        = 32'h3020_0073;
    localparam int          c_MTVEC = 0, c_MEPC = 1, c_MSTATUS = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] in_inst = 32'd0;
    logic        in_write = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_rs1 = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic [31:0] rdata, redirect_pc, mtvec, mepc, mstatus;
    logic        busy, redirect;

    int n_vec  = 0;
    int n_fail = 0;

    csr_regfile #(
        .RESET_MTVEC  (c_RESET_MTVEC),
        .MSTATUS_MASK (c_MASK)
    ) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .csrregin_inst         (in_inst),
        .csrregin_csr_write    (in_write),
        .csrregin_valid        (in_valid),
        .csrregin_rs1_data     (in_rs1),
        .csrregin_pc           (in_pc),
        .csrregout_rdata       (rdata),
        .csrregout_busy        (busy),
        .csrregout_redirect    (redirect),
        .csrregout_redirect_pc (redirect_pc),
        .csrregout_mtvec       (mtvec),
        .csrregout_mepc        (mepc),
        .csrregout_mstatus     (mstatus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_csr [3];
    int          m_cycles_left = 0;  // cycles of busy remaining; 1 means redirect cycle
    bit          m_is_trap = 1'b0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_target = 32'd0;

    function automatic int csr_index(input logic [11:0] a);
        case (a)
            12'h305: return c_MTVEC;
            12'h341: return c_MEPC;
            12'h300: return c_MSTATUS;
            default: return -1;
        endcase
    endfunction

    function automatic bit is_csr_op(input logic [31:0] inst);
        return (inst[6:0] == 7'h73) && (inst[14:12] inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111});
    endfunction

    function automatic logic [31:0] exp_rdata();
        int idx;
        idx = csr_index(in_inst[31:20]);
        if (!is_csr_op(in_inst) || idx < 0) return 32'd0;
        return m_csr[idx];
    endfunction

    // Architectural effect of one clock edge (or asynchronous reset)
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_csr[c_MTVEC]   = c_RESET_MTVEC;
            m_csr[c_MEPC]    = 32'd0;
            m_csr[c_MSTATUS] = 32'h0000_1800;
            m_cycles_left    = 0;
            m_target         = 32'd0;
        end else if (m_cycles_left == 2) begin
            logic mie, mpie;
            mie  = m_csr[c_MSTATUS][3];
            mpie = m_csr[c_MSTATUS][7];
            if (m_is_trap) begin
                m_csr[c_MEPC] = m_pc & ~32'd3;
                m_csr[c_MSTATUS][7] = mie;
                m_csr[c_MSTATUS][3] = 1'b0;
                m_target = m_csr[c_MTVEC];
            end else begin
                m_csr[c_MSTATUS][3] = mpie;
                m_csr[c_MSTATUS][7] = 1'b1;
                m_target = m_csr[c_MEPC];
            end
            m_csr[c_MSTATUS][12:11] = 2'b11;
            m_cycles_left = 1;
        end else if (m_cycles_left == 1) begin
            m_cycles_left = 0;
        end else if (in_valid && (in_inst == c_ECALL || in_inst == c_MRET)) begin
            m_is_trap     = (in_inst == c_ECALL);
            m_pc          = in_pc;
            m_cycles_left = 2;
        end else if (in_valid && in_write && is_csr_op(in_inst)) begin
            int          idx;
            logic [2:0]  f3;
            logic [31:0] src, old, nv;
            idx = csr_index(in_inst[31:20]);
            f3  = in_inst[14:12];
            src = f3[2] ? 32'(in_inst[19:15]) : in_rs1;
            if (idx >= 0 && !(f3[1:0] != 2'b01 && in_inst[19:15] == 5'd0)) begin
                old = m_csr[idx];
                if (f3[1:0] == 2'b01)      nv = src;
                else if (f3[1:0] == 2'b10) nv = old | src;
                else                       nv = old & ~src;
                if (idx == c_MSTATUS) m_csr[idx] = (old & ~c_MASK) | (nv & c_MASK);
                else                  m_csr[idx] = nv & ~32'd3;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model every cycle, mid-period
    always @(negedge clk) begin
        chk("rdata",       rdata,               exp_rdata());
        chk("busy",        {31'd0, busy},       {31'd0, m_cycles_left != 0});
        chk("redirect",    {31'd0, redirect},   {31'd0, m_cycles_left == 1});
        chk("redirect_pc", redirect_pc,         (m_cycles_left == 1) ? m_target : 32'd0);
        chk("mtvec",       mtvec,               m_csr[c_MTVEC]);
        chk("mepc",        mepc,                m_csr[c_MEPC]);
        chk("mstatus",     mstatus,             m_csr[c_MSTATUS]);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] inst, input logic v, input logic w,
                         input logic [31:0] rs1, input logic [31:0] pc);
        @(posedge clk);
        #1;
        in_inst  = inst;
        in_valid = v;
        in_write = w;
        in_rs1   = rs1;
        in_pc    = pc;
    endtask

    task automatic idle();
        drive(32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] csr_inst(input logic [11:0] a, input logic [4:0] rs1f,
                                             input logic [2:0] f3, input logic [4:0] rd);
        return {a, rs1f, f3, rd, 7'h73};
    endfunction

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("lit_rst_mtvec",   mtvec,   32'h0000_0000);
        chk("lit_rst_mstatus", mstatus, 32'h0000_1800);
        chk("lit_rst_busy",    {31'd0, busy}, 32'd0);
        #1 rstn = 1'b1;

        // CSRRW x1, mtvec, x2
        drive(csr_inst(12'h305, 5'd2, 3'b001, 5'd1), 1'b1, 1'b1, 32'h8000_0103, 32'd0);
        @(negedge clk); #1;
        chk("lit_csrrw_rdata", rdata, 32'h0000_0000);
        idle();
        chk("lit_csrrw_mtvec", mtvec, 32'h8000_0100);

        // mtvec=0x100, mstatus |= MIE via CSRRSI
        drive(csr_inst(12'h305, 5'd2, 3'b001, 5'd1), 1'b1, 1'b1, 32'h0000_0100, 32'd0);
        drive(csr_inst(12'h300, 5'd8, 3'b110, 5'd0), 1'b1, 1'b1, 32'd0, 32'd0);
        idle();
        chk("lit_setup_mstatus", mstatus, 32'h0000_1808);

        // ECALL at pc 0x40; CSRRW mtvec offered while busy must be ignored
        drive(c_ECALL, 1'b1, 1'b1, 32'd0, 32'h0000_0040);
        drive(csr_inst(12'h305, 5'd2, 3'b001, 5'd1), 1'b1, 1'b1, 32'hDEAD_0000, 32'd0);
        chk("lit_ecall_busy1", {31'd0, busy}, 32'd1);
        drive(csr_inst(12'h305, 5'd2, 3'b001, 5'd1), 1'b1, 1'b1, 32'hDEAD_0000, 32'd0);
        chk("lit_ecall_redir",   {31'd0, redirect}, 32'd1);
        chk("lit_ecall_pc",      redirect_pc, 32'h0000_0100);
        chk("lit_ecall_mepc",    mepc,        32'h0000_0040);
        chk("lit_ecall_mstatus", mstatus,     32'h0000_1880);
        idle();
        chk("lit_busy_mtvec", mtvec, 32'h0000_0100);

        // MRET
        drive(c_MRET, 1'b1, 1'b0, 32'd0, 32'd0);
        idle();
        idle();
        chk("lit_mret_pc",      redirect_pc, 32'h0000_0040);
        chk("lit_mret_mstatus", mstatus,     32'h0000_1888);
        idle();

        // CSRRS mstatus with x0: read only
        drive(csr_inst(12'h300, 5'd0, 3'b010, 5'd3), 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd0);
        @(negedge clk); #1;
        chk("lit_csrrs0_rdata", rdata, 32'h0000_1888);
        idle();
        chk("lit_csrrs0_mstatus", mstatus, 32'h0000_1888);

        // CSRRCI mstatus, 8 clears MIE
        drive(csr_inst(12'h300, 5'd8, 3'b111, 5'd0), 1'b1, 1'b1, 32'd0, 32'd0);
        idle();
        chk("lit_csrrci_mstatus", mstatus, 32'h0000_1880);

        // mepc write aligns; unmapped address reads zero; valid=0 blocks write
        drive(csr_inst(12'h341, 5'd2, 3'b001, 5'd1), 1'b1, 1'b1, 32'h0000_1237, 32'd0);
        drive(csr_inst(12'h340, 5'd2, 3'b011, 5'd1), 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd0);
        chk("lit_mepc_align", mepc, 32'h0000_1234);
        drive(csr_inst(12'h305, 5'd2, 3'b001, 5'd1), 1'b0, 1'b1, 32'h0000_0AA0, 32'd0);
        drive(csr_inst(12'h300, 5'd2, 3'b001, 5'd1), 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd0);
        chk("lit_novalid_mtvec", mtvec, 32'h0000_0100);
        drive(csr_inst(12'h300, 5'd2, 3'b001, 5'd1), 1'b1, 1'b1, 32'h0000_0000, 32'd0);
        chk("lit_mask_mstatus", mstatus, 32'h0000_1888);
        idle();

        // ECALL aborted by reset during TRAP_SAVE
        drive(c_ECALL, 1'b1, 1'b0, 32'd0, 32'h0000_0080);
        idle();
        #2 rstn = 1'b0;
        @(negedge clk); #1;
        chk("lit_abort_busy",    {31'd0, busy}, 32'd0);
        chk("lit_abort_mstatus", mstatus, 32'h0000_1800);
        chk("lit_abort_mepc",    mepc,    32'h0000_0000);
        #1 rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("lit_abort_noredir", {31'd0, redirect}, 32'd0);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
